// File: rtl/alu_control_md.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_md
// Summary  : ALU select decoder with an optional RV32M multiply/divide
//            sequencer. MUL* takes two cycles. DIV/REM uses a radix-2
//            restoring divider that produces one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_md #(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      alu_sel,
  output logic            stall_o,
  output logic            md_done_o,
  output logic [XLEN-1:0] md_result_o
);

  localparam logic [3:0] c_SEL_AND  = 4'b0000;
  localparam logic [3:0] c_SEL_OR   = 4'b0001;
  localparam logic [3:0] c_SEL_ADD  = 4'b0010;
  localparam logic [3:0] c_SEL_XOR  = 4'b0100;
  localparam logic [3:0] c_SEL_SUB  = 4'b0110;
  localparam logic [3:0] c_SEL_SLL  = 4'b0111;
  localparam logic [3:0] c_SEL_SRL  = 4'b1000;
  localparam logic [3:0] c_SEL_SRA  = 4'b1001;
  localparam logic [3:0] c_SEL_SLT  = 4'b1010;
  localparam logic [3:0] c_SEL_SLTU = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Base ALU select decode from alu_op / funct3 / funct7[5]
  always_comb begin
    alu_sel = c_SEL_AND;
    case (alu_op)
      2'b00: alu_sel = c_SEL_ADD;
      2'b01: alu_sel = c_SEL_SUB;
      2'b10: begin
        case ({funct3, funct7_5})
          4'b0000: alu_sel = c_SEL_ADD;
          4'b0001: alu_sel = c_SEL_SUB;
          4'b1110: alu_sel = c_SEL_AND;
          4'b1100: alu_sel = c_SEL_OR;
          4'b1000: alu_sel = c_SEL_XOR;
          4'b0010: alu_sel = c_SEL_SLL;
          4'b1010: alu_sel = c_SEL_SRL;
          4'b1011: alu_sel = c_SEL_SRA;
          4'b0100: alu_sel = c_SEL_SLT;
          4'b0110: alu_sel = c_SEL_SLTU;
          default: alu_sel = c_SEL_AND;
        endcase
      end
      default: begin
        case (funct3)
          3'b000:  alu_sel = c_SEL_ADD;
          3'b111:  alu_sel = c_SEL_AND;
          3'b110:  alu_sel = c_SEL_OR;
          3'b100:  alu_sel = c_SEL_XOR;
          3'b001:  alu_sel = c_SEL_SLL;
          3'b010:  alu_sel = c_SEL_SLT;
          3'b011:  alu_sel = c_SEL_SLTU;
          3'b101:  alu_sel = funct7_5 ? c_SEL_SRA : c_SEL_SRL;
          default: alu_sel = c_SEL_AND;
        endcase
      end
    endcase
  end

  generate
    if (MD_EN != 0) begin : g_md
      localparam logic [5:0]      c_CNT_INIT = 6'(XLEN - 1);
      localparam logic [XLEN-1:0] c_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

      state_t            r_state;
      state_t            w_next;
      logic [XLEN-1:0]   r_op_a;    // multiplicand, or dividend/quotient shift register
      logic [XLEN-1:0]   r_op_b;    // multiplier, or divisor magnitude
      logic [XLEN-1:0]   r_rem;
      logic [XLEN-1:0]   r_result;
      logic [5:0]        r_cnt;
      logic [1:0]        r_f3;
      logic              r_neg_q;
      logic              r_neg_r;

      logic              w_start;
      logic              w_div_signed;
      logic              w_rs1_neg;
      logic              w_rs2_neg;
      logic [XLEN-1:0]   w_abs1;
      logic [XLEN-1:0]   w_abs2;
      logic              w_div_zero;
      logic              w_div_ovf;
      logic              w_div_special;
      logic [XLEN-1:0]   w_special_res;
      logic [XLEN:0]     w_sub_in;
      logic [XLEN:0]     w_diff;
      logic              w_ge;
      logic [XLEN-1:0]   w_rem_nx;
      logic [XLEN-1:0]   w_quo_nx;
      logic [XLEN-1:0]   w_div_res;
      logic              w_a_signed;
      logic              w_b_signed;
      logic [2*XLEN-1:0] w_a_ext;
      logic [2*XLEN-1:0] w_b_ext;
      logic [2*XLEN-1:0] w_prod;
      logic [XLEN-1:0]   w_mul_res;

      // A new M op is only accepted from IDLE and never on a flushed cycle
      assign w_start = valid_i & (alu_op == 2'b10) & funct7_0 & ~flush_i & (r_state == S_IDLE);

      // Divide operand preparation: magnitudes and the single-cycle corner cases
      assign w_div_signed  = ~funct3[0];
      assign w_rs1_neg     = w_div_signed & rs1_i[XLEN-1];
      assign w_rs2_neg     = w_div_signed & rs2_i[XLEN-1];
      assign w_abs1        = w_rs1_neg ? -rs1_i : rs1_i;
      assign w_abs2        = w_rs2_neg ? -rs2_i : rs2_i;
      assign w_div_zero    = (rs2_i == '0);
      assign w_div_ovf     = w_div_signed & (rs1_i == c_MOST_NEG) & (rs2_i == '1);
      assign w_div_special = w_div_zero | w_div_ovf;
      assign w_special_res = w_div_zero ? (funct3[1] ? rs1_i : '1)
                                        : (funct3[1] ? '0    : rs1_i);

      // One restoring step: shift the next dividend bit into the partial remainder
      assign w_sub_in  = {r_rem, r_op_a[XLEN-1]};
      assign w_diff    = w_sub_in - {1'b0, r_op_b};
      assign w_ge      = ~w_diff[XLEN];
      assign w_rem_nx  = w_ge ? w_diff[XLEN-1:0] : {r_rem[XLEN-2:0], r_op_a[XLEN-1]};
      assign w_quo_nx  = {r_op_a[XLEN-2:0], w_ge};
      assign w_div_res = r_f3[1] ? (r_neg_r ? -w_rem_nx : w_rem_nx)
                                 : (r_neg_q ? -w_quo_nx : w_quo_nx);

      // Multiply: extend each operand per its signedness, then keep low or high half
      assign w_a_signed = (r_f3 == 2'b01) | (r_f3 == 2'b10);
      assign w_b_signed = (r_f3 == 2'b01);
      assign w_a_ext    = {{XLEN{w_a_signed & r_op_a[XLEN-1]}}, r_op_a};
      assign w_b_ext    = {{XLEN{w_b_signed & r_op_b[XLEN-1]}}, r_op_b};
      assign w_prod     = w_a_ext * w_b_ext;
      assign w_mul_res  = (r_f3 == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

      // Sequencer state register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= S_IDLE;
        end else begin
          r_state <= w_next;
        end
      end

      // Sequencer next-state logic
      always_comb begin
        w_next = r_state;
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              if (!funct3[2])         w_next = S_MUL;
              else if (w_div_special) w_next = S_DONE;
              else                    w_next = S_DIV;
            end
          end
          S_MUL:   w_next = flush_i ? S_IDLE : S_DONE;
          S_DIV: begin
            if (flush_i)              w_next = S_IDLE;
            else if (r_cnt == '0)     w_next = S_DONE;
          end
          default: w_next = S_IDLE;
        endcase
      end

      // Operand capture, divider iteration and result register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_op_a   <= '0;
          r_op_b   <= '0;
          r_rem    <= '0;
          r_result <= '0;
          r_cnt    <= '0;
          r_f3     <= '0;
          r_neg_q  <= 1'b0;
          r_neg_r  <= 1'b0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_start) begin
                r_f3  <= funct3[1:0];
                r_cnt <= c_CNT_INIT;
                r_rem <= '0;
                if (funct3[2]) begin
                  r_op_a  <= w_abs1;
                  r_op_b  <= w_abs2;
                  r_neg_q <= w_rs1_neg ^ w_rs2_neg;
                  r_neg_r <= w_rs1_neg;
                  if (w_div_special) r_result <= w_special_res;
                end else begin
                  r_op_a  <= rs1_i;
                  r_op_b  <= rs2_i;
                  r_neg_q <= 1'b0;
                  r_neg_r <= 1'b0;
                end
              end
            end
            S_MUL: begin
              if (!flush_i) r_result <= w_mul_res;
            end
            S_DIV: begin
              if (!flush_i) begin
                r_op_a <= w_quo_nx;
                r_rem  <= w_rem_nx;
                if (r_cnt != '0) r_cnt <= r_cnt - 6'd1;
                else             r_result <= w_div_res;
              end
            end
            default: ;
          endcase
        end
      end

      assign stall_o     = w_start | (r_state == S_MUL) | (r_state == S_DIV);
      assign md_done_o   = (r_state == S_DONE);
      assign md_result_o = r_result;
    end else begin : g_no_md
      logic w_unused_md;
      assign w_unused_md = ^{clk, rst_n, valid_i, funct7_0, flush_i, rs1_i, rs2_i};
      assign stall_o     = 1'b0;
      assign md_done_o   = 1'b0;
      assign md_result_o = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/alu_control_md.md
ALU_CONTROL_MD -- requirements
Module: alu_control_md

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64.
REQ-002 Parameter MD_EN, default 1, 1 = RV32M multiply/divide sequencer present, 0 = sequencer absent.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 valid_i  input  1  EX-stage instruction valid.
REQ-006 alu_op  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-007 funct3  input  3  instruction bits [14:12].
REQ-008 funct7_5  input  1  instruction bit 30.
REQ-009 funct7_0  input  1  instruction bit 25, M-extension select.
REQ-010 flush_i  input  1  abort in-flight M operation.
REQ-011 rs1_i, rs2_i  input  XLEN each  forwarded operands.
REQ-012 alu_sel  output  4  base ALU select, combinational.
REQ-013 stall_o  output  1  hold IF/ID/EX while M operation is pending.
REQ-014 md_done_o  output  1  one-cycle pulse, md_result_o valid.
REQ-015 md_result_o  output  XLEN  M-operation result.

Function
REQ-016 alu_sel: 00->0010, 01->0110, others->0000 unless decoded below.
REQ-017 alu_op=10, key {funct3,funct7_5}: 0000 ADD 0010, 0001 SUB 0110, 1110 AND 0000, 1100 OR 0001, 1000 XOR 0100, 0010 SLL 0111, 1010 SRL 1000, 1011 SRA 1001, 0100 SLT 1010, 0110 SLTU 1011, other 0000.
REQ-018 alu_op=11: by funct3 as ADDI/ANDI/ORI/XORI/SLLI/SLTI/SLTIU above; funct3=101 gives 1000 when funct7_5=0, 1001 (SRAI) when funct7_5=1.
REQ-019 start = valid_i & alu_op=10 & funct7_0 & MD_EN & state IDLE; alu_sel is don't-care for M ops.
REQ-020 States: IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-021 IDLE: on start latch rs1_i, rs2_i, funct3; funct3[2]=0 -> MUL, funct3[2]=1 -> DIV, or DONE directly if divisor zero or signed overflow.
REQ-022 MUL: compute 2*XLEN product (MUL low; MULH s*s, MULHSU s*u, MULHU u*u high half), -> DONE next cycle; start-to-done latency 2.
REQ-023 DIV: restoring radix-2, one quotient bit per cycle, 6-bit counter from XLEN-1 to 0, -> DONE after XLEN cycles; latency XLEN+1.
REQ-024 Signed DIV/REM: divide magnitudes; quotient negated if signs differ; remainder takes dividend sign.
REQ-025 Divisor zero: DIV/DIVU result all ones, REM/REMU result dividend; latency 1.
REQ-026 Signed overflow (dividend = most-negative, divisor = -1): DIV result dividend, REM result 0; latency 1.
REQ-027 DONE: md_done_o=1, md_result_o valid, stall_o=0, -> IDLE next cycle; start not accepted in DONE.
REQ-028 stall_o = start | (state is MUL or DIV); combinational, so the issuing instruction is held from its first EX cycle.
REQ-029 md_result_o holds last result until next DONE.
REQ-030 flush_i in MUL/DIV: -> IDLE next edge, no md_done_o, md_result_o unchanged; flush_i in IDLE suppresses start.
REQ-031 flush_i in DONE: md_done_o still pulses that cycle; -> IDLE.
REQ-032 MD_EN=0: sequencer not generated; stall_o, md_done_o, md_result_o tied 0; funct7_0 ignored.

Reset
REQ-033 rst_n low: state IDLE, counter 0, operand registers 0, md_result_o 0, md_done_o 0, stall_o 0 (valid_i low), immediately and independent of clk.
REQ-034 Reset mid-DIV/MUL aborts the operation; no md_done_o after release.
REQ-035 First start accepted on first rising edge after rst_n deasserts.

Verification
REQ-036 alu_op=11, funct3=101, funct7_5=1 -> alu_sel=1001; funct7_5=0 -> 1000; alu_op=10 key 0001 -> 0110.
REQ-037 DIV rs1=7, rs2=0xFFFFFFFE -> stall_o 33 cycles, md_done_o at cycle 33, result 0xFFFFFFFD; REM same operands -> 0x00000001.
REQ-038 DIVU rs1=5, rs2=0 -> done cycle 1, result 0xFFFFFFFF; REMU -> 0x00000005; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-039 MULH rs1=rs2=0x80000000 -> done cycle 2, result 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL -> 0x00000001.
REQ-040 flush_i at DIV cycle 10 -> IDLE next cycle, stall_o 0, no md_done_o; rst_n low at cycle 5 of DIV -> all outputs 0 asynchronously.
